// File: rtl/float_align_stage.sv
// float_align_stage
//   Operand pre-alignment ahead of the binary32 adder. Two register stages:
//     S1: unpack x/y, classify special values, order by magnitude, compute
//         the exponent difference d = exp_b - exp_s.
//     S2: right-shift the smaller mantissa by d, folding shifted-out bits
//         into a sticky LSB.
//   Latency 2, throughput 1 per cycle.
//
//   Handshake (valid/ready): a transfer happens on a rising edge where
//   valid & ready are both high. The producer holds its payload steady while
//   valid & !ready. en = !out_valid | out_ready advances both stages
//   together; when en=0 every register holds, so the outputs stay frozen.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   in_valid/in_ready, x, y  operand input handshake, binary32 operands
//   out_valid/out_ready      result handshake
//   out_sign_b/out_sign_s    signs of larger / smaller magnitude operand
//   out_eff_sub              out_sign_b ^ out_sign_s
//   out_exp                  common exponent (exponent of larger operand)
//   out_mant_b/out_mant_s    {hidden,frac,GRS} of larger / aligned smaller
//   out_class                0 normal,1 NaN,2 +inf,3 -inf,4 zero,5 bypass
module float_align_stage #(
  parameter int GRS_W     = 3,
  parameter bit FLUSH_DEN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           x,
  input  logic [31:0]           y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign_b,
  output logic                  out_sign_s,
  output logic                  out_eff_sub,
  output logic [7:0]            out_exp,
  output logic [24+GRS_W-1:0]   out_mant_b,
  output logic [24+GRS_W-1:0]   out_mant_s,
  output logic [2:0]            out_class
);

  localparam int         MW   = 24 + GRS_W;
  localparam logic [7:0] MW_D = 8'(MW);

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_NAN    = 3'd1,
    CLS_PINF   = 3'd2,
    CLS_NINF   = 3'd3,
    CLS_ZERO   = 3'd4,
    CLS_BYPASS = 3'd5
  } cls_e;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack / classify / order ----------------
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_big;
  logic [23:0] x_mant, y_mant;
  logic [7:0]  x_eexp, y_eexp;

  assign x_zero = (x[30:23] == 8'h00) && (FLUSH_DEN || (x[22:0] == 23'd0));
  assign y_zero = (y[30:23] == 8'h00) && (FLUSH_DEN || (y[22:0] == 23'd0));
  assign x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  assign y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
  assign x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  assign y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
  assign x_mant = x_zero ? 24'd0 : {x[30:23] != 8'h00, x[22:0]};
  assign y_mant = y_zero ? 24'd0 : {y[30:23] != 8'h00, y[22:0]};
  // Kept denormals behave as exponent 1 when measuring the shift distance.
  assign x_eexp = (!FLUSH_DEN && x[30:23] == 8'h00) ? 8'd1 : x[30:23];
  assign y_eexp = (!FLUSH_DEN && y[30:23] == 8'h00) ? 8'd1 : y[30:23];
  // Magnitude order on {exp,frac}; a tie keeps x as the larger operand.
  assign x_big  = x[30:0] >= y[30:0];

  logic          c_sign_b, c_sign_s;
  logic [7:0]    c_exp, c_d;
  logic [MW-1:0] c_mant_b;
  logic [23:0]   c_mant_s;
  logic [2:0]    c_class;

  always_comb begin
    c_sign_b = x_big ? x[31] : y[31];
    c_sign_s = x_big ? y[31] : x[31];
    c_exp    = x_big ? x[30:23] : y[30:23];
    c_mant_b = {(x_big ? x_mant : y_mant), {GRS_W{1'b0}}};
    c_mant_s = x_big ? y_mant : x_mant;
    c_d      = x_big ? (x_eexp - y_eexp) : (y_eexp - x_eexp);
    c_class  = CLS_NORMAL;
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) begin
      c_class  = CLS_NAN;
      c_exp    = 8'hFF;
      c_mant_b = '1;
    end else if (x_inf || y_inf) begin
      c_class = (x_inf ? x[31] : y[31]) ? CLS_NINF : CLS_PINF;
    end else if (x_zero && y_zero) begin
      c_class  = CLS_ZERO;
      c_sign_b = x[31] & y[31];
    end else if (x_zero || y_zero) begin
      // Larger operand is already the nonzero one (zero has exp field 0).
      c_class  = CLS_BYPASS;
      c_mant_s = '0;
    end
  end

  logic          s1_valid, s1_sign_b, s1_sign_s;
  logic [7:0]    s1_exp, s1_d;
  logic [MW-1:0] s1_mant_b;
  logic [23:0]   s1_mant_s;
  logic [2:0]    s1_class;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_sign_s <= 1'b0;
      s1_exp    <= '0;
      s1_d      <= '0;
      s1_mant_b <= '0;
      s1_mant_s <= '0;
      s1_class  <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sign_b <= c_sign_b;
      s1_sign_s <= c_sign_s;
      s1_exp    <= c_exp;
      s1_d      <= c_d;
      s1_mant_b <= c_mant_b;
      s1_mant_s <= c_mant_s;
      s1_class  <= c_class;
    end
  end

  // ---------------- S2: align with sticky ----------------
  logic [MW-1:0] ext, sh;

  always_comb begin
    ext = {s1_mant_s, {GRS_W{1'b0}}};
    if (s1_d >= MW_D) begin
      sh = {{(MW-1){1'b0}}, |ext};
    end else begin
      sh = (ext >> s1_d) |
           {{(MW-1){1'b0}}, |(ext & ~({MW{1'b1}} << s1_d))};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_sign_b  <= 1'b0;
      out_sign_s  <= 1'b0;
      out_eff_sub <= 1'b0;
      out_exp     <= '0;
      out_mant_b  <= '0;
      out_mant_s  <= '0;
      out_class   <= '0;
    end else if (en) begin
      out_valid   <= s1_valid;
      out_sign_b  <= s1_sign_b;
      out_sign_s  <= s1_sign_s;
      out_eff_sub <= s1_sign_b ^ s1_sign_s;
      out_exp     <= s1_exp;
      out_mant_b  <= s1_mant_b;
      out_mant_s  <= sh;
      out_class   <= s1_class;
    end
  end

endmodule
